// File: rtl/ks_pkg.sv
// Shared constants, state encoding and the LFSR step function used by
// ks_lfsr16 and by the top block's sample mapping.
package ks_pkg;

  localparam int          B        = 8;
  localparam logic [15:0] SEED_DEF = 16'hACE1;
  localparam logic [15:0] TAPS_DEF = 16'hB400;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  // Galois step: shift right, fold the ejected bit back through the taps
  function automatic logic [15:0] lfsr_step(input logic [15:0] cur,
                                            input logic [15:0] taps);
    logic [15:0] nxt;
    nxt = cur >> 1;
    if (cur[0]) nxt = nxt ^ taps;
    return nxt;
  endfunction

endpackage

// File: rtl/ks_lfsr16.sv
// 16-bit Galois LFSR noise source; advances one step when 'step' is high.
module ks_lfsr16
  import ks_pkg::*;
#(
  parameter logic [15:0] SEED = SEED_DEF,
  parameter logic [15:0] TAPS = TAPS_DEF
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        step,
  output logic [15:0] q
);

  logic [15:0] r_q;

  always_ff @(posedge CLK) begin
    if (RST)       r_q <= SEED;
    else if (step) r_q <= lfsr_step(r_q, TAPS);
  end

  assign q = r_q;

endmodule

// File: rtl/ks_excitation_gen.sv
// Karplus-Strong pluck source: on TRIG emits LEN attenuated noise samples
// on I at the SAMPLE_EN rate, then returns I to zero and pulses DONE.
module ks_excitation_gen
  import ks_pkg::*;
#(
  parameter int          B     = ks_pkg::B,
  parameter int          LEN_W = 8,
  parameter logic [15:0] SEED  = SEED_DEF,
  parameter logic [15:0] TAPS  = TAPS_DEF
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                TRIG,
  input  logic [LEN_W-1:0]    LEN,
  input  logic [2:0]          AMP_SHIFT,
  input  logic                SAMPLE_EN,
  output logic signed [B-1:0] I,
  output logic                BUSY,
  output logic                DONE
);

  typedef logic signed [B-1:0] samp_t;
  localparam samp_t S_MIN = samp_t'({1'b1, {(B-1){1'b0}}});
  localparam samp_t S_SYM = samp_t'({1'b1, {(B-2){1'b0}}, 1'b1});

  state_t           r_state, w_state_nxt;
  logic [LEN_W-1:0] r_cnt,   w_cnt_nxt;
  logic [LEN_W-1:0] r_len,   w_len_nxt;
  logic [2:0]       r_amp,   w_amp_nxt;
  samp_t            r_i,     w_i_nxt;
  logic             r_done,  w_done_nxt;
  logic             w_step;

  logic [15:0] w_lfsr_q;
  logic [15:0] w_lfsr_nxt;
  samp_t       w_raw;
  samp_t       w_sym;
  samp_t       w_scaled;

  ks_lfsr16 #(
    .SEED (SEED),
    .TAPS (TAPS)
  ) u_lfsr (
    .CLK  (CLK),
    .RST  (RST),
    .step (w_step),
    .q    (w_lfsr_q)
  );

  // The emitted sample comes from the value the LFSR is about to take
  assign w_lfsr_nxt = lfsr_step(w_lfsr_q, TAPS);
  assign w_raw      = samp_t'(w_lfsr_nxt);
  assign w_sym      = (w_raw == S_MIN) ? S_SYM : w_raw;
  assign w_scaled   = w_sym >>> r_amp;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_len   <= '0;
      r_amp   <= '0;
      r_i     <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_len   <= w_len_nxt;
      r_amp   <= w_amp_nxt;
      r_i     <= w_i_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_len_nxt   = r_len;
    w_amp_nxt   = r_amp;
    w_i_nxt     = r_i;
    w_done_nxt  = 1'b0;
    w_step      = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_i_nxt = '0;
        if (TRIG) begin
          w_len_nxt = LEN;
          w_amp_nxt = AMP_SHIFT;
          w_cnt_nxt = '0;
          if (LEN != '0) w_state_nxt = BURST;
          else           w_done_nxt  = 1'b1;
        end
      end
      BURST: begin
        if (TRIG) begin
          // Retrigger restarts the count but keeps the noise sequence running
          w_len_nxt = LEN;
          w_amp_nxt = AMP_SHIFT;
          w_cnt_nxt = '0;
          if (LEN == '0) begin
            w_state_nxt = IDLE;
            w_i_nxt     = '0;
            w_done_nxt  = 1'b1;
          end
        end else if (SAMPLE_EN) begin
          if (r_cnt < r_len) begin
            w_step    = 1'b1;
            w_i_nxt   = w_scaled;
            w_cnt_nxt = r_cnt + 1'b1;
          end else begin
            w_state_nxt = IDLE;
            w_i_nxt     = '0;
            w_done_nxt  = 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign I    = r_i;
  assign BUSY = (r_state == BURST);
  assign DONE = r_done;

endmodule

// File: tb/tb_ks_excitation_gen.sv
// Scoreboard bench: drivers push hand-computed {I,BUSY,DONE} events, a
// monitor pops one whenever I changes or DONE is seen.
module tb_ks_excitation_gen;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              TRIG = 1'b0;
  logic [7:0]        LEN = '0;
  logic [2:0]        AMP_SHIFT = '0;
  logic              SAMPLE_EN = 1'b0;
  logic signed [7:0] I;
  logic              BUSY;
  logic              DONE;

  ks_excitation_gen #(.B(8), .LEN_W(8)) dut (
    .CLK(CLK), .RST(RST), .TRIG(TRIG), .LEN(LEN), .AMP_SHIFT(AMP_SHIFT),
    .SAMPLE_EN(SAMPLE_EN), .I(I), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic signed [7:0] i;
    logic              busy;
    logic              done;
  } ev_t;

  ev_t q[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  bit  mon_off = 1'b0;
  logic signed [7:0] prev_i = '0;
  int  busy_cnt = 0;
  int  bad_cnt = 0;
  int  nz_cnt = 0;

  task automatic push(input int i, input bit b, input bit d);
    ev_t e;
    e.i = 8'(i); e.busy = b; e.done = d;
    q.push_back(e);
  endtask

  task automatic chk(input string nm, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: every I change or DONE pulse is one observed event
  always @(negedge CLK) begin
    if (!mon_off && (DONE !== 1'b0 || I !== prev_i)) begin
      n_tests++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event: got I=%0d BUSY=%b DONE=%b expected none",
                 I, BUSY, DONE);
      end else begin
        ev_t e;
        e = q.pop_front();
        if (I !== e.i || BUSY !== e.busy || DONE !== e.done) begin
          n_fail++;
          $display("FAIL event: got I=%0d BUSY=%b DONE=%b expected I=%0d BUSY=%b DONE=%b",
                   I, BUSY, DONE, e.i, e.busy, e.done);
        end
      end
    end
    if (mon_off) begin
      if ($isunknown(I) || I == -8'sd128) bad_cnt++;
      if (I != 0) nz_cnt++;
    end
    if (BUSY === 1'b1) busy_cnt++;
    prev_i = I;
  end

  task automatic wait_drain(input string nm);
    for (int k = 0; k < 60 && q.size() != 0; k++) @(negedge CLK);
    repeat (2) @(negedge CLK);
    chk({nm, "_pending"}, q.size(), 0);
    q.delete();
  endtask

  task automatic do_reset();
    @(negedge CLK); RST = 1'b1; TRIG = 1'b0; SAMPLE_EN = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic strobe();
    repeat (3) begin @(negedge CLK); TRIG = 1'b0; SAMPLE_EN = 1'b0; end
    @(negedge CLK); SAMPLE_EN = 1'b1;
  endtask

  initial begin
    int b0;
    // Reset with TRIG and SAMPLE_EN active
    RST = 1'b1; TRIG = 1'b1; SAMPLE_EN = 1'b1; LEN = 8'd3;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      chk("rst_I", I, 0);
      chk("rst_BUSY", BUSY, 0);
      chk("rst_DONE", DONE, 0);
    end
    chk("rst_lfsr", dut.u_lfsr.q, 32'hACE1);
    RST = 1'b0; TRIG = 1'b0; SAMPLE_EN = 1'b0;
    @(negedge CLK);

    // Basic burst
    @(negedge CLK); TRIG = 1'b1; LEN = 8'd3; AMP_SHIFT = 3'd0; SAMPLE_EN = 1'b1;
    push(112, 1, 0); push(56, 1, 0); push(-100, 1, 0); push(0, 0, 1);
    b0 = busy_cnt;
    @(negedge CLK); TRIG = 1'b0;
    wait_drain("basic");
    chk("basic_busy_cycles", busy_cnt - b0, 4);

    // Attenuation from a fresh seed
    do_reset();
    @(negedge CLK); TRIG = 1'b1; LEN = 8'd3; AMP_SHIFT = 3'd2; SAMPLE_EN = 1'b1;
    push(28, 1, 0); push(14, 1, 0); push(-25, 1, 0); push(0, 0, 1);
    @(negedge CLK); TRIG = 1'b0;
    wait_drain("atten");

    // Zero-length trigger
    @(negedge CLK); TRIG = 1'b1; LEN = 8'd0; AMP_SHIFT = 3'd0; SAMPLE_EN = 1'b1;
    push(0, 0, 1);
    b0 = busy_cnt;
    @(negedge CLK); TRIG = 1'b0;
    wait_drain("len0");
    chk("len0_busy_cycles", busy_cnt - b0, 0);

    // Strobe gating then retrigger after the 2nd sample
    do_reset();
    @(negedge CLK); TRIG = 1'b1; LEN = 8'd5; SAMPLE_EN = 1'b0;
    push(112, 1, 0); push(56, 1, 0);
    strobe(); strobe();
    @(negedge CLK); TRIG = 1'b1; LEN = 8'd5; SAMPLE_EN = 1'b0;
    push(-100, 1, 0); push(78, 1, 0); push(39, 1, 0);
    push(19, 1, 0); push(-119, 1, 0); push(0, 0, 1);
    repeat (6) strobe();
    @(negedge CLK); SAMPLE_EN = 1'b0;
    wait_drain("strobe_retrig");

    // Reset mid-burst: no DONE, next burst starts from the seed again
    do_reset();
    @(negedge CLK); TRIG = 1'b1; LEN = 8'd5; SAMPLE_EN = 1'b1;
    push(112, 1, 0); push(56, 1, 0); push(0, 0, 0);
    @(negedge CLK); TRIG = 1'b0;
    @(negedge CLK);
    @(negedge CLK); RST = 1'b1;
    @(negedge CLK); RST = 1'b0; TRIG = 1'b1; LEN = 8'd2;
    push(112, 1, 0); push(56, 1, 0); push(0, 0, 1);
    @(negedge CLK); TRIG = 1'b0;
    wait_drain("mid_reset");

    // Long chained burst: symmetric range and no X
    @(negedge CLK); mon_off = 1'b1; TRIG = 1'b1; LEN = 8'd255;
    AMP_SHIFT = 3'd0; SAMPLE_EN = 1'b1;
    for (int c = 0; c < 20200; c++) begin
      @(negedge CLK);
      TRIG = (c % 200 == 199);
    end
    TRIG = 1'b0;
    repeat (300) @(negedge CLK);
    chk("long_bad_samples", bad_cnt, 0);
    chk("long_active", (nz_cnt > 19000) ? 1 : 0, 1);
    chk("long_idle_I", I, 0);
    chk("long_idle_BUSY", BUSY, 0);
    @(negedge CLK); mon_off = 1'b0;
    repeat (3) @(negedge CLK);
    chk("final_queue", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ks_excitation_gen.md
Name: ks_excitation_gen

Overview:
Upstream excitation source for music_synthesizer.
- On a trigger, emits a burst of LEN pseudo-random signed 8-bit samples on I, then holds I at zero. This is the Karplus-Strong "pluck" noise that fills the synthesizer delay line.
- Sample rate is set by an external strobe, so one sample can advance per synthesizer clock or slower.
- Replaces the behavioural $random stimulus with synthesizable hardware.

Parameters:
B, 8, sample width; must equal the synthesizer I width; legal range 2..16
LEN_W, 8, width of the burst-length input
SEED, 16'hACE1, LFSR value at reset; must be nonzero
TAPS, 16'hB400, Galois LFSR feedback mask (x^16+x^14+x^13+x^11+1)

Ports:
CLK  in  1  clock; all state updates on the rising edge
RST  in  1  synchronous, active-high reset
TRIG  in  1  start or restart a burst; level-sampled, one-cycle pulse expected
LEN  in  LEN_W  burst length in samples; latched when TRIG is accepted
AMP_SHIFT  in  3  attenuation (arithmetic right shift); latched when TRIG is accepted
SAMPLE_EN  in  1  sample-rate strobe
I  out  B  signed excitation sample; drives music_synthesizer I
BUSY  out  1  high while a burst is in progress
DONE  out  1  single-cycle pulse at burst end

Behaviour:
- Reset (RST=1 at an edge):
  - I=0, BUSY=0, DONE=0, state=IDLE, cnt=0, lfsr=SEED.
  - RST has priority over every other input, including mid-burst; the burst is abandoned and DONE is not pulsed.
- States: IDLE, BURST. BUSY is a registered output and equals (state==BURST).
- DONE defaults to 0 every cycle; it is 1 only in the cycle after a completion event.
- IDLE:
  - TRIG=1 latches len_q=LEN and amp_q=AMP_SHIFT, and sets cnt=0.
  - If LEN!=0, go to BURST. If LEN==0, stay in IDLE and pulse DONE next cycle.
  - SAMPLE_EN is ignored in IDLE, including in the TRIG cycle. I holds 0.
- BURST, evaluated in priority order:
  1. TRIG=1 (retrigger): relatch LEN/AMP_SHIFT, cnt=0, I holds its value, no LFSR step. If the new LEN==0, go to IDLE, set I=0, pulse DONE.
  2. SAMPLE_EN=1 and cnt<len_q: step the LFSR, set I=scaled sample, cnt=cnt+1.
  3. SAMPLE_EN=1 and cnt==len_q: set I=0, go to IDLE, pulse DONE.
  4. Otherwise hold all state.
- Latency: I changes on the SAMPLE_EN edge. Exactly len_q nonzero-path samples are emitted, then one zeroing edge. BUSY is high for all of them.
- LFSR step (Galois): lsb=lfsr[0]; lfsr=lfsr>>1; if lsb, lfsr^=TAPS.
  - The LFSR is not reset by TRIG, so successive notes get different noise.
  - The LFSR never reaches zero.
- Sample: raw = new lfsr[B-1:0], interpreted as signed.
  - If raw == -2^(B-1), substitute -(2^(B-1)-1). This makes the range symmetric (±127 for B=8).
  - Then I = raw >>> amp_q (arithmetic shift, sign preserved).
  - Shifts up to 7 are legal; a result of -1 is allowed.
- No output is ever X after reset. No combinational path from inputs to outputs.

Decomposition:
- Package ks_pkg: state enum (IDLE, BURST); default SEED and TAPS constants; sample-width constant B shared with music_synthesizer.
- Sub-module ks_lfsr16: ports CLK, RST, step, q[15:0]; parameters SEED and TAPS. The top block holds the FSM, counter, latches, and the sample mapping/shift.

Test Plan:
- Reset: hold RST for 3 cycles with TRIG=1 and SAMPLE_EN=1 → I=0, BUSY=0, DONE=0 throughout; internal lfsr=16'hACE1.
- Basic burst: after reset, TRIG with LEN=3, AMP_SHIFT=0, SAMPLE_EN always 1.
  - I = 0x70 (112), 0x38 (56), 0x9C (-100) on consecutive edges.
  - Next edge: I=0, DONE=1 for exactly one cycle.
  - BUSY is high for 4 cycles.
- Attenuation: same as the basic burst but AMP_SHIFT=2 → I = 28, 14, -25 (0xE7), then 0.
- LEN=0: TRIG in IDLE → DONE=1 on the following cycle; BUSY never rises; I stays 0.
- Strobe gating and retrigger:
  - LEN=5, SAMPLE_EN high one cycle in four → I changes only on strobe edges and holds between them.
  - TRIG after the 2nd sample → count restarts, 5 further samples continuing the LFSR sequence (no repeat of 112), then a single DONE.
- Mid-burst reset plus long run:
  - RST asserted after the 2nd sample → no DONE; I=0; the next burst restarts at 112.
  - Over a 20000-sample burst (LEN chained by retrigger), assert I ≠ -128 and I never X.
